// File: rtl/matmul_pkg.sv
// Shared constants, widths and state types for the matmul output side.
// Used by the drain, its serializer and the bus interface.
package matmul_pkg;

    localparam int R_DEF   = 8;
    localparam int C_DEF   = 8;
    localparam int W_X_DEF = 8;
    localparam int W_K_DEF = 8;
    localparam int W_O_DEF = 8;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } ser_state_e;

    function automatic int depth(input int c);
        return $clog2(c);
    endfunction

    function automatic int w_y(input int w_x, input int w_k, input int c);
        return w_x + w_k + depth(c);
    endfunction

    function automatic int beats(input int tot, input int w_o);
        return (tot + w_o - 1) / w_o;
    endfunction

endpackage

// File: rtl/matvec_drain_if.sv
// Multiplier-side and beat-stream signals of the drain.
// slave is the drain's view, master the environment's view.
interface matvec_drain_if
    import matmul_pkg::*;
#(
    parameter int R   = R_DEF,
    parameter int C   = C_DEF,
    parameter int W_X = W_X_DEF,
    parameter int W_K = W_K_DEF,
    parameter int W_O = W_O_DEF
) ();

    localparam int TOT = R * w_y(W_X, W_K, C);

    logic           in_valid;
    logic           in_ready;
    logic           cen;
    logic [TOT-1:0] y;
    logic [W_O-1:0] m_data;
    logic           m_valid;
    logic           m_ready;
    logic           m_last;

    modport slave (
        input  in_valid, y, m_ready,
        output in_ready, cen, m_data, m_valid, m_last
    );

    modport master (
        output in_valid, y, m_ready,
        input  in_ready, cen, m_data, m_valid, m_last
    );

endinterface

// File: rtl/matvec_drain_ser.sv
// One-deep result buffer streamed out as W_O-bit beats, LSB first.
// o_ready is high when the buffer can take i_load on this edge.
module matvec_drain_ser
    import matmul_pkg::*;
#(
    parameter int TOT = 18,
    parameter int W_O = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_load,
    input  logic [TOT-1:0] i_data,
    output logic           o_ready,
    output logic [W_O-1:0] o_data,
    output logic           o_valid,
    output logic           o_last,
    input  logic           i_m_ready
);

    localparam int BEATS = beats(TOT, W_O);
    localparam int PW    = BEATS * W_O;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LASTB = BW'(BEATS - 1);

    ser_state_e    r_state;
    ser_state_e    w_nstate;
    logic [PW-1:0] r_buf;
    logic [BW-1:0] r_beat;
    logic          w_full;
    logic          w_fire;
    logic          w_end;
    logic          w_load;

    assign w_full = (r_state == S_SEND);
    assign w_fire = w_full && i_m_ready;
    assign w_end  = w_fire && (r_beat == LASTB);
    assign w_load = i_load && !w_full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nstate;
        end
    end

    always_comb begin
        w_nstate = r_state;
        unique case (r_state)
            S_IDLE: if (w_load) w_nstate = S_SEND;
            S_SEND: if (w_end) w_nstate = S_IDLE;
            default: w_nstate = S_IDLE;
        endcase
    end

    // Buffer is zero-extended so the tail of the last beat reads as 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_buf  <= '0;
            r_beat <= '0;
        end else if (w_load) begin
            r_buf  <= PW'(i_data);
            r_beat <= '0;
        end else if (w_fire) begin
            r_beat <= w_end ? '0 : r_beat + BW'(1);
        end
    end

    assign o_ready = !w_full;
    assign o_valid = w_full;
    assign o_last  = w_full && (r_beat == LASTB);
    assign o_data  = w_full ? r_buf[int'(r_beat) * W_O +: W_O] : '0;

endmodule

// File: rtl/matvec_drain.sv
// Multiplier valid tracking and clock-enable, feeding the beat serializer.
// cen depends on registered state only, never on m_ready.
module matvec_drain
    import matmul_pkg::*;
#(
    parameter int R   = R_DEF,
    parameter int C   = C_DEF,
    parameter int W_X = W_X_DEF,
    parameter int W_K = W_K_DEF,
    parameter int W_O = W_O_DEF
) (
    input logic           clk,
    input logic           rst_n,
    matvec_drain_if.slave bus
);

    localparam int LAT = depth(C) + 1;
    localparam int W_Y = w_y(W_X, W_K, C);
    localparam int TOT = R * W_Y;

    logic [LAT-1:0] r_vpipe;
    logic [LAT-1:0] w_vnext;
    logic           w_head;
    logic           w_ready;
    logic           w_cen;

    assign w_head = r_vpipe[LAT-1];
    assign w_cen  = !(w_head && !w_ready);

    always_comb begin
        w_vnext    = '0;
        w_vnext[0] = bus.in_valid;
        for (int i = 1; i < LAT; i++) begin
            w_vnext[i] = r_vpipe[i-1];
        end
    end

    // Shifting with cen consumes the head in the same edge it is captured.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vpipe <= '0;
        end else if (w_cen) begin
            r_vpipe <= w_vnext;
        end
    end

    assign bus.cen      = w_cen;
    assign bus.in_ready = w_cen;

    matvec_drain_ser #(
        .TOT(TOT),
        .W_O(W_O)
    ) u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_head && w_ready),
        .i_data   (bus.y),
        .o_ready  (w_ready),
        .o_data   (bus.m_data),
        .o_valid  (bus.m_valid),
        .o_last   (bus.m_last),
        .i_m_ready(bus.m_ready)
    );

endmodule

// File: tb/tb_matvec_drain.sv
// Scoreboard bench for matvec_drain with a cen-gated multiplier model.
// Expected beats are cut from each launched vector with plain shifts.
module tb_matvec_drain;
    import matmul_pkg::*;

    localparam int R     = 2;
    localparam int C     = 2;
    localparam int WX    = 4;
    localparam int WK    = 4;
    localparam int WO    = 8;
    localparam int LAT   = depth(C) + 1;
    localparam int TOT   = R * w_y(WX, WK, C);
    localparam int BEATS = beats(TOT, WO);

    typedef struct {
        logic [WO-1:0] d;
        logic          l;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matvec_drain_if #(.R(R), .C(C), .W_X(WX), .W_K(WK), .W_O(WO)) bus ();

    matvec_drain #(.R(R), .C(C), .W_X(WX), .W_K(WK), .W_O(WO)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [TOT-1:0] r_vec;
    logic [TOT-1:0] mp [LAT];
    beat_t          exp_q [$];
    int             n_pass = 0;
    int             n_tot = 0;
    int             nbeats = 0;

    assign bus.y = mp[LAT-1];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endfunction

    function automatic void fail(string nm);
        n_tot++;
        $display("FAIL %s: timed out", nm);
    endfunction

    // Multiplier model plus scoreboard push on each accepted launch.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else if (bus.in_valid && bus.in_ready) begin
            for (int b = 0; b < BEATS; b++) begin
                exp_q.push_back('{d: WO'(r_vec >> (b * WO)), l: (b == BEATS - 1)});
            end
        end
        if (bus.cen) begin
            mp[0] <= bus.in_valid ? r_vec : TOT'($urandom);
            for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
        end
    end

    logic          prev_stall = 1'b0;
    logic [WO-1:0] prev_d;
    logic          prev_l;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            chk("cen_eq_ready", bus.cen, bus.in_ready);
            if (prev_stall) begin
                chk("hold_valid", bus.m_valid, 1);
                chk("hold_data", bus.m_data, prev_d);
                chk("hold_last", bus.m_last, prev_l);
            end
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    n_tot++;
                    $display("FAIL spurious_beat: got %0h want none", bus.m_data);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", bus.m_data, e.d);
                    chk("beat_last", bus.m_last, e.l);
                    nbeats++;
                end
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_d     = bus.m_data;
            prev_l     = bus.m_last;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [TOT-1:0] v);
        @(posedge clk);
        #1;
        r_vec = v;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        r_vec = TOT'($urandom);
    endtask

    task automatic wait_mvalid(input string nm);
        int k = 0;
        while (!bus.m_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!bus.m_valid) fail(nm);
    endtask

    task automatic drain(input string nm);
        int k = 0;
        while ((exp_q.size() != 0 || bus.m_valid) && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0 || bus.m_valid) fail(nm);
    endtask

    initial begin
        logic [7:0] ed [3];
        logic       acc;
        int         n;
        int         guard;
        int         stalls;

        bus.in_valid = 1'b0;
        bus.m_ready  = 1'b1;
        r_vec        = '0;
        for (int i = 0; i < LAT; i++) mp[i] = '0;
        repeat (2) step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", bus.m_valid, 0);
        chk("rst_last", bus.m_last, 0);
        chk("rst_data", bus.m_data, 0);
        chk("rst_cen", bus.cen, 1);

        // Single vector: fixed latency and known beats.
        ed[0] = 8'hF3; ed[1] = 8'h4A; ed[2] = 8'h03;
        launch({9'h1A5, 9'h0F3});
        @(negedge clk);
        chk("lat_e0", bus.m_valid, 0);
        @(negedge clk);
        chk("lat_e1", bus.m_valid, 0);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            chk("single_valid", bus.m_valid, 1);
            chk("single_data", bus.m_data, ed[b]);
            chk("single_last", bus.m_last, (b == 2) ? 1 : 0);
        end
        @(negedge clk);
        chk("single_done", bus.m_valid, 0);

        // Backpressure mid-vector.
        launch(TOT'($urandom));
        wait_mvalid("bp_wait");
        step();
        bus.m_ready = 1'b0;
        repeat (5) step();
        bus.m_ready = 1'b1;
        drain("bp_drain");

        // Four back-to-back launches force a stall.
        @(posedge clk);
        #1;
        nbeats = 0;
        n = 0;
        guard = 0;
        stalls = 0;
        r_vec = TOT'($urandom);
        while (n < 4 && guard < 100) begin
            bus.in_valid = 1'b1;
            acc = bus.in_ready;
            if (!acc) stalls++;
            step();
            if (acc) begin
                n++;
                r_vec = TOT'($urandom);
            end
            guard++;
        end
        bus.in_valid = 1'b0;
        drain("stall_drain");
        chk("stall_launches", n, 4);
        chk("stall_beats", nbeats, 12);
        chk("stall_seen", (stalls > 0) ? 1 : 0, 1);

        // All-ones vector shows zero padding in the last beat.
        launch('1);
        wait_mvalid("pad_wait");
        chk("pad0", bus.m_data, 8'hFF);
        @(negedge clk);
        chk("pad1", bus.m_data, 8'hFF);
        @(negedge clk);
        chk("pad2", bus.m_data, 8'h03);
        chk("pad2_last", bus.m_last, 1);
        drain("pad_drain");

        // Reset while beat 1 is presented, then a quiet stretch.
        launch(TOT'($urandom));
        wait_mvalid("rst_wait");
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", bus.m_valid, 0);
        chk("mid_rst_cen", bus.cen, 1);
        chk("mid_rst_data", bus.m_data, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_valid", bus.m_valid, 0);
            chk("idle_cen", bus.cen, 1);
        end
        chk("rst_flushed", exp_q.size(), 0);

        // Random traffic with random downstream readiness.
        @(posedge clk);
        #1;
        for (int c = 0; c < 400; c++) begin
            if (!(bus.in_valid && !bus.in_ready)) begin
                bus.in_valid = ($urandom_range(0, 2) == 0);
                r_vec = TOT'($urandom);
            end
            bus.m_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.in_valid = 1'b0;
        bus.m_ready  = 1'b1;
        drain("rand_drain");
        chk("final_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
